hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard detector for the 5-stage pipeline, where branches are resolved in decode.
- Keeps a shadow shift register of in-flight destination registers instead of consuming per-stage pipeline-register fields.
- Produces the decode stall/bubble request, optional forwarding selects, and a saturating stall-cycle counter.
- Sits beside the IF/ID register; drives the control-mux bubble select and the PC/IF_ID write-enables.

Parameters:
- REG_AW, 5: register address width; register 0 is hard-wired zero and never causes a hazard.
- LAT, 3: number of stages after decode that hold a pending write (EX, MEM, WB); legal range 2..6.
- FWD_EN, 0: 0 = stall-only mode (no forwarding); 1 = forwarding mode with load-use and branch interlocks.
- WB_BYPASS, 1: 1 = register file is write-before-read, so the last shadow stage never matches.
- CNT_W, 16: width of the stall counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ID_Valid  in  1  decode holds a real instruction.
- ID_Rs  in  REG_AW  decode source register rs.
- ID_Rt  in  REG_AW  decode source register rt.
- ID_UseRs  in  1  instruction reads rs.
- ID_UseRt  in  1  instruction reads rt (R-type, store, branch).
- ID_Branch  in  1  instruction is a branch compared in decode.
- ID_Dst  in  REG_AW  destination register after the RegDst mux.
- ID_RegWrite  in  1  instruction writes ID_Dst.
- ID_MemRead  in  1  instruction is a load.
- ID_Flush  in  1  decode instruction is squashed (taken branch or jump).
- CntClear  in  1  synchronous clear of StallCount.
- Stall  out  1  hold PC and IF_ID; insert a bubble into ID_EX.
- FwdRs  out  3  rs operand source: 0 = register file, k = shadow stage k (1 = EX).
- FwdRt  out  3  rt operand source, same encoding as FwdRs.
- StallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow: LAT entries of {v, dst, ld}. Entry 1 is the instruction now in EX; entry LAT is the one in WB.
- Every cycle, entries shift one place toward LAT and entry LAT is discarded.
- The new entry 1 is set as follows:
  - Issue (ID_Valid & !Stall & !ID_Flush): {ID_RegWrite & (ID_Dst != 0), ID_Dst, ID_MemRead}.
  - Otherwise: a bubble with v = 0.
- A stall never freezes the shadow; downstream stages keep draining.
- Match(k, r) = v[k] & dst[k] == r & r != 0 & (k < LAT | !WB_BYPASS). It applies only to sources whose Use flag is set.
- Stall is combinational from current state plus decode inputs. It is 0 whenever !ID_Valid or ID_Flush.
- FWD_EN = 0: Stall = 1 if any stage k matches a used source.
- FWD_EN = 1: Stall = 1 on any of:
  - a used source matches stage 1 with ld = 1 (load-use);
  - ID_Branch and a used source matches stage 1 (any instruction);
  - ID_Branch and a used source matches stage 2 with ld = 1.
- FwdRs / FwdRt:
  - Value is the smallest k with Match (youngest writer wins), else 0.
  - Forced to 0 when FWD_EN = 0 or Stall = 1.
- StallCount:
  - Increments on each cycle with Stall = 1 and saturates at all-ones.
  - If CntClear and Stall are both 1 in the same cycle, the result is 0; clear wins.
- Reset (async assert, sync-safe deassert): all v = 0, StallCount = 0. Stall and Fwd outputs are therefore 0 immediately.
- Reset asserted mid-stall discards all pending entries; the first instruction after reset never stalls.
- Multiple matches: no double-counting; one stall cycle increments the counter by 1.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW;
  - the FWD_* encodings (FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3);
  - the shadow-entry struct {v, dst, ld}.
- One natural sub-module, hazard_match: a combinational comparator over all shadow entries for one source. It is instantiated twice (rs, rt) and returns the match vector plus the youngest index.

Test Plan:
- FWD_EN = 0: `add $3,$1,$2` then `sub $4,$3,$5` → Stall = 1 for 2 cycles (WB_BYPASS = 1), StallCount = 2; `sub` issues on the 3rd cycle.
- FWD_EN = 1: `lw $8,0($9)` then `add $10,$8,$8` → exactly 1 stall cycle; on the next cycle FwdRs = FwdRt = 2 (MEM).
- FWD_EN = 1: `add $3,...` then `beq $3,$4` → 1 stall cycle, then FwdRs = 2. With `lw $3` instead → 2 stall cycles.
- Destination $0: `addi $0,$0,5` then `add $1,$0,$0` → Stall = 0, FwdRs = FwdRt = 0, StallCount unchanged.
- Youngest wins: `add $5` then `or $5` then `and $6,$5,$5` (FWD_EN = 1) → FwdRs = 1, not 2.
- Flush and reset:
  - ID_Flush = 1 on a dependent instruction → Stall = 0 and a bubble enters.
  - Reset_n pulsed low mid-stall → Stall falls asynchronously and StallCount = 0.
  - Counter with CNT_W = 2 saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register address width, forwarding-source
// encodings and the shadow-entry layout used by the hazard scoreboard.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] FWD_RF  = 3'd0;
  localparam logic [2:0] FWD_EX  = 3'd1;
  localparam logic [2:0] FWD_MEM = 3'd2;
  localparam logic [2:0] FWD_WB  = 3'd3;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } shadow_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source against every shadow entry; returns the hit
// vector (bit k-1 = stage k) and the youngest matching stage (0 = none).
import pipe_pkg::*;

module hazard_match #(
  parameter int unsigned LAT       = 3,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  shadow_t           shadow [LAT],
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  output logic [LAT-1:0]    hit,
  output logic [2:0]        youngest
);

  always_comb begin
    hit      = '0;
    youngest = FWD_RF;
    // Walk oldest to youngest so the youngest writer is the last one assigned.
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      if (use_src && shadow[k].v && (shadow[k].dst == src) && (src != '0) &&
          ((k < int'(LAT) - 1) || !WB_BYPASS)) begin
        hit[k]   = 1'b1;
        youngest = 3'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations in a shadow
// shift register and produces stall, forwarding selects and a stall counter.
import pipe_pkg::*;

module hazard_scoreboard #(
  parameter int unsigned REG_AW    = pipe_pkg::REG_AW,
  parameter int unsigned LAT       = 3,
  parameter bit          FWD_EN    = 1'b0,
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ID_Valid,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic              ID_Branch,
  input  logic [REG_AW-1:0] ID_Dst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_Flush,
  input  logic              CntClear,
  output logic              Stall,
  output logic [2:0]        FwdRs,
  output logic [2:0]        FwdRt,
  output logic [CNT_W-1:0]  StallCount
);

  shadow_t          sh_q [LAT];
  shadow_t          new_entry;
  logic [LAT-1:0]   hit_rs, hit_rt, hit_any;
  logic [2:0]       young_rs, young_rt;
  logic             hazard;
  logic             issue;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  hazard_match #(
    .LAT       (LAT),
    .WB_BYPASS (WB_BYPASS)
  ) u_match_rs (
    .shadow   (sh_q),
    .src      (ID_Rs),
    .use_src  (ID_UseRs),
    .hit      (hit_rs),
    .youngest (young_rs)
  );

  hazard_match #(
    .LAT       (LAT),
    .WB_BYPASS (WB_BYPASS)
  ) u_match_rt (
    .shadow   (sh_q),
    .src      (ID_Rt),
    .use_src  (ID_UseRt),
    .hit      (hit_rt),
    .youngest (young_rt)
  );

  assign hit_any = hit_rs | hit_rt;

  always_comb begin
    if (FWD_EN) begin
      // Only results not yet produced in time for forwarding cause a stall.
      hazard = (hit_any[0] & sh_q[0].ld) |
               (ID_Branch & hit_any[0]) |
               (ID_Branch & hit_any[1] & sh_q[1].ld);
    end else begin
      hazard = |hit_any;
    end
    Stall = ID_Valid & ~ID_Flush & hazard;
    issue = ID_Valid & ~ID_Flush & ~Stall;
  end

  always_comb begin
    FwdRs = FWD_RF;
    FwdRt = FWD_RF;
    if (FWD_EN && !Stall) begin
      FwdRs = young_rs;
      FwdRt = young_rt;
    end
  end

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.v   = ID_RegWrite & (ID_Dst != '0);
      new_entry.dst = ID_Dst;
      new_entry.ld  = ID_MemRead;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (CntClear) begin
      cnt_d = '0;
    end else if (Stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The shadow shifts every cycle; a stall only injects a bubble into stage 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < int'(LAT); k++) begin
        sh_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      sh_q[0] <= new_entry;
      for (int k = 1; k < int'(LAT); k++) begin
        sh_q[k] <= sh_q[k-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a stall-only scoreboard (2-bit counter) and a forwarding
// scoreboard share one decode stream; each scenario checks one of them.
module tb_hazard_scoreboard;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       ID_Valid, ID_UseRs, ID_UseRt, ID_Branch, ID_RegWrite, ID_MemRead, ID_Flush;
  logic       CntClear;
  logic [4:0] ID_Rs, ID_Rt, ID_Dst;

  logic       stall0, stall1;
  logic [2:0] fwd_rs0, fwd_rt0, fwd_rs1, fwd_rt1;
  logic [1:0] cnt0;
  logic [15:0] cnt1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  hazard_scoreboard #(
    .LAT (3), .FWD_EN (1'b0), .WB_BYPASS (1'b1), .CNT_W (2)
  ) u_dut0 (
    .Clk (Clk), .Reset_n (Reset_n), .ID_Valid (ID_Valid), .ID_Rs (ID_Rs), .ID_Rt (ID_Rt),
    .ID_UseRs (ID_UseRs), .ID_UseRt (ID_UseRt), .ID_Branch (ID_Branch), .ID_Dst (ID_Dst),
    .ID_RegWrite (ID_RegWrite), .ID_MemRead (ID_MemRead), .ID_Flush (ID_Flush),
    .CntClear (CntClear), .Stall (stall0), .FwdRs (fwd_rs0), .FwdRt (fwd_rt0),
    .StallCount (cnt0)
  );

  hazard_scoreboard #(
    .LAT (3), .FWD_EN (1'b1), .WB_BYPASS (1'b1), .CNT_W (16)
  ) u_dut1 (
    .Clk (Clk), .Reset_n (Reset_n), .ID_Valid (ID_Valid), .ID_Rs (ID_Rs), .ID_Rt (ID_Rt),
    .ID_UseRs (ID_UseRs), .ID_UseRt (ID_UseRt), .ID_Branch (ID_Branch), .ID_Dst (ID_Dst),
    .ID_RegWrite (ID_RegWrite), .ID_MemRead (ID_MemRead), .ID_Flush (ID_Flush),
    .CntClear (CntClear), .Stall (stall1), .FwdRs (fwd_rs1), .FwdRt (fwd_rt1),
    .StallCount (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic [4:0] dst, input logic rw, input logic mr,
                       input logic fl);
    ID_Valid = v;   ID_Rs = rs;   ID_Rt = rt;   ID_UseRs = urs; ID_UseRt = urt;
    ID_Branch = br; ID_Dst = dst; ID_RegWrite = rw; ID_MemRead = mr; ID_Flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    CntClear = 1'b0;
    idle();
    #12 Reset_n = 1'b1;
    step();
    check("rst_stall0", stall0, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_stall1", stall1, 0);
    check("rst_fwd1", {fwd_rs1, fwd_rt1}, 0);

    // Stall-only: add $3,$1,$2 ; sub $4,$3,$5 -> two stalls, then issue.
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    check("a_add_nostall", stall0, 0);
    step();
    drive(1, 3, 5, 1, 1, 0, 4, 1, 0, 0);
    check("a_sub_stall1", stall0, 1);
    check("a_fwd_forced0", fwd_rs0, 0);
    step();
    check("a_sub_stall2", stall0, 1);
    check("a_cnt1", cnt0, 1);
    step();
    check("a_sub_issue", stall0, 0);
    check("a_cnt2", cnt0, 2);
    step();
    // and $6,$4,$4 -> two more stalls, 2-bit counter saturates at 3.
    drive(1, 4, 4, 1, 1, 0, 6, 1, 0, 0);
    check("a_and_stall", stall0, 1);
    step();
    check("a_cnt3", cnt0, 3);
    check("a_and_stall2", stall0, 1);
    step();
    check("a_and_issue", stall0, 0);
    check("a_cnt_sat", cnt0, 3);
    idle();
    CntClear = 1'b1;
    step();
    CntClear = 1'b0;
    check("a_cnt_clear", cnt0, 0);

    // Forwarding: lw $8,0($9) ; add $10,$8,$8 -> one stall, then MEM forward.
    do_reset();
    step();
    drive(1, 9, 0, 1, 0, 0, 8, 1, 1, 0);
    check("b_lw_nostall", stall1, 0);
    step();
    drive(1, 8, 8, 1, 1, 0, 10, 1, 0, 0);
    check("b_loaduse_stall", stall1, 1);
    check("b_fwd_forced0", fwd_rs1, 0);
    step();
    check("b_after_stall", stall1, 0);
    check("b_fwd_rs_mem", fwd_rs1, 2);
    check("b_fwd_rt_mem", fwd_rt1, 2);
    check("b_cnt1", cnt1, 1);

    // Branch: add $3 ; beq $3,$4 -> one stall then rs from MEM.
    do_reset();
    step();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    step();
    drive(1, 3, 4, 1, 1, 1, 0, 0, 0, 0);
    check("c_beq_stall", stall1, 1);
    step();
    check("c_beq_issue", stall1, 0);
    check("c_beq_fwd_rs", fwd_rs1, 2);
    check("c_beq_fwd_rt", fwd_rt1, 0);
    step();
    idle();
    step(); step(); step();
    // lw $3 ; beq $3,$4 -> two stalls.
    drive(1, 9, 0, 1, 0, 0, 3, 1, 1, 0);
    step();
    drive(1, 3, 4, 1, 1, 1, 0, 0, 0, 0);
    check("c_lwbr_stall1", stall1, 1);
    step();
    check("c_lwbr_stall2", stall1, 1);
    step();
    check("c_lwbr_issue", stall1, 0);
    check("c_lwbr_fwd_wb_bypass", fwd_rs1, 0);
    check("c_cnt3", cnt1, 3);

    // Destination $0: addi $0,$0,5 ; add $1,$0,$0 -> no hazard anywhere.
    do_reset();
    step();
    drive(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 1, 1, 0, 1, 1, 0, 0);
    check("d_zero_stall0", stall0, 0);
    check("d_zero_stall1", stall1, 0);
    check("d_zero_fwd", {fwd_rs1, fwd_rt1}, 0);
    step();
    check("d_zero_cnt1", cnt1, 0);

    // Youngest wins: add $5 ; or $5 ; and $6,$5,$5.
    do_reset();
    step();
    drive(1, 1, 2, 1, 1, 0, 5, 1, 0, 0);
    step();
    drive(1, 1, 2, 1, 1, 0, 5, 1, 0, 0);
    step();
    drive(1, 5, 5, 1, 1, 0, 6, 1, 0, 0);
    check("e_young_stall", stall1, 0);
    check("e_young_rs", fwd_rs1, 1);
    check("e_young_rt", fwd_rt1, 1);

    // Flush: dependent sub squashed -> no stall, and its $4 never enters.
    do_reset();
    step();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    step();
    drive(1, 3, 5, 1, 1, 0, 4, 1, 0, 1);
    check("f_flush_stall", stall0, 0);
    step();
    drive(1, 4, 4, 1, 1, 0, 7, 1, 0, 0);
    check("f_bubble_entered", stall0, 0);
    step();

    // Reset mid-stall: stall drops asynchronously, counter clears.
    do_reset();
    step();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    step();
    drive(1, 3, 5, 1, 1, 0, 4, 1, 0, 0);
    check("g_pre_stall", stall0, 1);
    step();
    check("g_pre_cnt", cnt0, 1);
    #1 Reset_n = 1'b0;
    #1;
    check("g_async_stall", stall0, 0);
    check("g_async_cnt", cnt0, 0);
    #1 Reset_n = 1'b1;
    step();
    check("g_first_after_rst", stall0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
